// File: rtl/pipelined_adder_pkg.sv
// Shared op encoding and slice-width helper for the pipelined adder.
package pipelined_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Guarded so a bad STAGES value reaches the elaboration check instead of a divide-by-zero.
  function automatic int slice_width(input int size, input int stages);
    return (stages > 0) ? size / stages : size;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// W-bit combinational slice adder with carry in/out.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline gates its registers.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// SIZE-bit add/subtract, carry rippled across STAGES registered slices.
// Latency: STAGES cycles from accept to out_valid, 1 beat/cycle.
// Backpressure: whole pipeline freezes when out_valid && !out_ready; in_ready drops with it.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int SIZE   = 32,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            cin,
  input  logic            op_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] SUM,
  output logic            cout,
  output logic            ovf
);

  localparam int SLICE = slice_width(SIZE, STAGES);

  if ((STAGES < 1) || (SIZE % STAGES != 0)) begin : g_bad_param
    $error("pipelined_adder: SIZE must be a multiple of STAGES and STAGES >= 1");
  end

  // Operands shift down by one slice per stage, so the slice being added is always
  // at bit 0; sums shift in from the top so slice 0 lands at bit 0 after the last stage.
  logic [SIZE-1:0]  a_cur   [STAGES];
  logic [SIZE-1:0]  b_cur   [STAGES];
  logic [SIZE-1:0]  res_cur [STAGES];
  logic             c_cur   [STAGES];
  logic             v_cur   [STAGES];
  logic [SLICE-1:0] s_sum   [STAGES];
  logic             s_co    [STAGES];

  logic [SIZE-1:0]  a_q     [STAGES];
  logic [SIZE-1:0]  b_q     [STAGES];
  logic [SIZE-1:0]  res_q   [STAGES];
  logic             cy_q    [STAGES];
  logic             vld_q   [STAGES];
  logic             ovf_q;
  logic             adv;

  assign adv       = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign SUM       = res_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign ovf       = ovf_q;

  always_comb begin
    a_cur[0]   = A;
    b_cur[0]   = (op_sub == OP_SUB) ? ~B : B;
    c_cur[0]   = (op_sub == OP_ADD) ? cin : ~cin;
    v_cur[0]   = in_valid;
    res_cur[0] = '0;
    for (int s = 1; s < STAGES; s++) begin
      a_cur[s]   = a_q[s-1];
      b_cur[s]   = b_q[s-1];
      c_cur[s]   = cy_q[s-1];
      v_cur[s]   = vld_q[s-1];
      res_cur[s] = res_q[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    adder_slice #(.W(SLICE)) u_slice (
      .a   (a_cur[s][SLICE-1:0]),
      .b   (b_cur[s][SLICE-1:0]),
      .ci  (c_cur[s]),
      .sum (s_sum[s]),
      .co  (s_co[s])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        res_q[s] <= '0;
        cy_q[s]  <= 1'b0;
        vld_q[s] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= a_cur[s] >> SLICE;
        b_q[s]   <= b_cur[s] >> SLICE;
        res_q[s] <= (res_cur[s] >> SLICE) | (SIZE'(s_sum[s]) << (SIZE - SLICE));
        cy_q[s]  <= s_co[s];
        vld_q[s] <= v_cur[s];
      end
      // The top slice is only present in the last stage, so overflow is resolved there.
      ovf_q <= (a_cur[STAGES-1][SLICE-1] == b_cur[STAGES-1][SLICE-1]) &&
               (s_sum[STAGES-1][SLICE-1] != a_cur[STAGES-1][SLICE-1]);
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder at 32/4, 64/8 and 8/1.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv0, ir0, ci0, sb0, ov0, or0, co0, of0;
  logic [31:0] a0, b0, s0;
  logic        iv1, ir1, ci1, sb1, ov1, or1, co1, of1;
  logic [63:0] a1, b1, s1;
  logic        iv2, ir2, ci2, sb2, ov2, or2, co2, of2;
  logic [7:0]  a2, b2, s2;

  int n_chk  = 0;
  int n_pass = 0;

  pipelined_adder #(.SIZE(32), .STAGES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
    .cin(ci0), .op_sub(sb0), .out_valid(ov0), .out_ready(or0), .SUM(s0),
    .cout(co0), .ovf(of0));

  pipelined_adder #(.SIZE(64), .STAGES(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .cin(ci1), .op_sub(sb1), .out_valid(ov1), .out_ready(or1), .SUM(s1),
    .cout(co1), .ovf(of1));

  pipelined_adder #(.SIZE(8), .STAGES(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
    .cin(ci2), .op_sub(sb2), .out_valid(ov2), .out_ready(or2), .SUM(s2),
    .cout(co2), .ovf(of2));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [65:0] model64(input logic [63:0] a, input logic [63:0] b,
                                         input logic c, input logic sub);
    logic [63:0] bx;
    logic        cx;
    logic [64:0] f;
    bx = sub ? ~b : b;
    cx = sub ? ~c : c;
    f  = {1'b0, a} + {1'b0, bx} + {64'd0, cx};
    return {(a[63] == bx[63]) && (f[63] != a[63]), f};
  endfunction

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic sub);
    logic [7:0] bx;
    logic       cx;
    logic [8:0] f;
    bx = sub ? ~b : b;
    cx = sub ? ~c : c;
    f  = {1'b0, a} + {1'b0, bx} + {8'd0, cx};
    return {(a[7] == bx[7]) && (f[7] != a[7]), f};
  endfunction

  // Single beat with out_ready high: checks latency and the result fields.
  task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic sub, input logic [31:0] esum,
                      input logic ecout, input logic eovf);
    int lat;
    @(negedge clk);
    a0 = a; b0 = b; ci0 = c; sb0 = sub; iv0 = 1'b1;
    #1;
    check({tag, "_rdy"}, ir0, 1'b1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv0 = 1'b0;
    while (!ov0 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sum"}, s0, esum);
    check({tag, "_cout"}, co0, ecout);
    check({tag, "_ovf"}, of0, eovf);
  endtask

  // Eight beats A=B=base+i; mode 0 stalls out_ready for the first 10 cycles, mode 1 toggles it.
  task automatic stream(input string tag, input int base, input int mode);
    logic [31:0] q[$];
    logic [31:0] e;
    int idx = 0;
    int got = 0;
    logic acc, dlv;
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(negedge clk);
      or0 = (mode == 0) ? (c >= 10) : c[0];
      iv0 = (idx < 8);
      a0  = base + idx;
      b0  = base + idx;
      ci0 = 1'b0;
      sb0 = 1'b0;
      #1;
      if (mode == 0 && c == 9) begin
        check({tag, "_full_rdy"}, ir0, 1'b0);
        check({tag, "_full_vld"}, ov0, 1'b1);
        check({tag, "_stall_sum"}, s0, 2 * base);
      end
      acc = iv0 && ir0;
      dlv = ov0 && or0;
      if (dlv) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        check({tag, "_sum"}, s0, e);
        got++;
      end
      if (acc) begin
        q.push_back(2 * (base + idx));
        idx++;
      end
    end
    check({tag, "_count"}, got, 8);
    check({tag, "_left"}, q.size(), 0);
    iv0 = 1'b0;
    or0 = 1'b1;
  endtask

  initial begin
    int stale;
    int n_rnd;
    int sent1, sent2, rcv1, rcv2;
    logic [65:0] q1[$];
    logic [9:0]  q2[$];
    logic [65:0] e1;
    logic [9:0]  e2;

    rst_n = 1'b0;
    {iv0, ci0, sb0, a0, b0} = '0;
    {iv1, ci1, sb1, a1, b1} = '0;
    {iv2, ci2, sb2, a2, b2} = '0;
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_vld", ov0, 1'b0);
    check("rst_sum", s0, 32'h0);
    check("rst_cout", co0, 1'b0);
    check("rst_ovf", of0, 1'b0);
    check("rst_vld64", ov1, 1'b0);
    check("rst_vld8", ov2, 1'b0);
    rst_n = 1'b1;

    run1("add_ripple", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run1("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run1("sub_neg",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run1("sub_brw",    32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
    run1("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run1("add_cin",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);

    stream("bp", 1, 0);
    stream("tgl", 20, 1);

    // Reset with the first beat on the output and three more in flight.
    or0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      iv0 = 1'b1; a0 = 32'h100 * (k + 1); b0 = k + 1; ci0 = 1'b0; sb0 = 1'b0;
    end
    @(posedge clk);
    #1;
    check("rst_pre_vld", ov0, 1'b1);
    check("rst_pre_sum", s0, 32'h0000_0101);
    rst_n = 1'b0;
    #1;
    check("rst_mid_vld", ov0, 1'b0);
    check("rst_mid_sum", s0, 32'h0);
    check("rst_mid_cout", co0, 1'b0);
    iv0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov0) stale++;
    end
    check("rst_stale", stale, 0);
    run1("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    n_rnd = 10000;
    sent1 = 0; sent2 = 0; rcv1 = 0; rcv2 = 0;
    for (int c = 0; c < 60000 && (rcv1 < n_rnd || rcv2 < n_rnd); c++) begin
      @(negedge clk);
      iv1 = (sent1 < n_rnd) && ($urandom_range(0, 3) != 0);
      a1  = {$urandom, $urandom};
      b1  = {$urandom, $urandom};
      ci1 = $urandom_range(0, 1);
      sb1 = $urandom_range(0, 1);
      or1 = ($urandom_range(0, 3) != 0);
      iv2 = (sent2 < n_rnd) && ($urandom_range(0, 3) != 0);
      a2  = 8'($urandom);
      b2  = 8'($urandom);
      ci2 = $urandom_range(0, 1);
      sb2 = $urandom_range(0, 1);
      or2 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov1 && or1) begin
        e1 = (q1.size() > 0) ? q1.pop_front() : 'x;
        check("rnd64", {of1, co1, s1}, e1);
        rcv1++;
      end
      if (iv1 && ir1) begin
        q1.push_back(model64(a1, b1, ci1, sb1));
        sent1++;
      end
      if (ov2 && or2) begin
        e2 = (q2.size() > 0) ? q2.pop_front() : 'x;
        check("rnd8", {of2, co2, s2}, e2);
        rcv2++;
      end
      if (iv2 && ir2) begin
        q2.push_back(model8(a2, b2, ci2, sb2));
        sent2++;
      end
    end
    check("rnd64_count", rcv1, n_rnd);
    check("rnd8_count", rcv2, n_rnd);
    iv1 = 1'b0;
    iv2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
